// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, sync polarity and colour palette
// used by the timing generator and the graphics stage.
package vga_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int H_FP       = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BP       = 48;
    localparam int V_ACTIVE   = 480;
    localparam int V_FP       = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 33;
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CNT_W      = 10;
    localparam int CNT_LIMIT  = 1 << CNT_W;
    localparam int PIPE_DELAY = 1;

    localparam logic SYNC_POL = 1'b0;

    typedef logic [2:0] color_t;

    localparam color_t COLOR_BLACK = 3'b000;
    localparam color_t COLOR_BLUE  = 3'b001;
    localparam color_t COLOR_GREEN = 3'b010;
    localparam color_t COLOR_RED   = 3'b100;
    localparam color_t COLOR_WHITE = 3'b111;

    // Bundle carried through the alignment delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } sync_t;

    // Half-open window test; one bit wider than the counter so an end equal to 1024 still works.
    function automatic logic in_window(input logic [CNT_W:0] cnt,
                                       input logic [CNT_W:0] win_start,
                                       input logic [CNT_W:0] win_end);
        return (cnt >= win_start) && (cnt < win_end);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Parameterised width/depth shift register with a per-bit asynchronous reset value,
// used to align sync/blanking with downstream pixel pipelines.
module vga_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    if (DEPTH < 1) begin : g_depth_err
        $error("vga_delay_line: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: free-running pixel/line counters, sync and blanking
// re-aligned to the graphics pipeline latency, plus line/frame strobes.
module vga_sync
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int   H_FP       = vga_pkg::H_FP,
    parameter int   H_SYNC     = vga_pkg::H_SYNC,
    parameter int   H_BP       = vga_pkg::H_BP,
    parameter int   V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int   V_FP       = vga_pkg::V_FP,
    parameter int   V_SYNC     = vga_pkg::V_SYNC,
    parameter int   V_BP       = vga_pkg::V_BP,
    parameter logic SYNC_POL   = vga_pkg::SYNC_POL,
    parameter int   PIPE_DELAY = vga_pkg::PIPE_DELAY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       color_px,
    output logic [CNT_W-1:0] x_px,
    output logic [CNT_W-1:0] y_px,
    output logic             activevideo,
    output logic             hsync,
    output logic             vsync,
    output logic [2:0]       rgb,
    output logic             line_start,
    output logic             frame_start
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (HT > CNT_LIMIT) begin : g_h_err
        $error("vga_sync: horizontal total exceeds 1024");
    end
    if (VT > CNT_LIMIT) begin : g_v_err
        $error("vga_sync: vertical total exceeds 1024");
    end
    if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_pipe_err
        $error("vga_sync: PIPE_DELAY must be within 1..4");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VT - 1);
    localparam logic [CNT_W:0]   H_ACT_W  = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0]   V_ACT_W  = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0]   HS_START = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0]   HS_END   = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0]   VS_START = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0]   VS_END   = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    localparam sync_t SYNC_IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, act: 1'b0};

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    sync_t            sync_raw;
    sync_t            sync_dly;

    always_comb begin
        h_cnt_d       = h_cnt_q + CNT_W'(1);
        v_cnt_d       = v_cnt_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d      = '0;
            line_start_d = 1'b1;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d       = '0;
                frame_start_d = 1'b1;
            end else begin
                v_cnt_d = v_cnt_q + CNT_W'(1);
            end
        end
    end

    // Strobes are registered from "next count is zero", so none fires on the first cycle after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        sync_raw.hs  = in_window({1'b0, h_cnt_q}, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
        sync_raw.vs  = in_window({1'b0, v_cnt_q}, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
        sync_raw.act = ({1'b0, h_cnt_q} < H_ACT_W) && ({1'b0, v_cnt_q} < V_ACT_W);
    end

    vga_delay_line #(
        .WIDTH    ($bits(sync_t)),
        .DEPTH    (PIPE_DELAY),
        .RESET_VAL(SYNC_IDLE)
    ) u_align (
        .clk   (clk),
        .reset (reset),
        .data_i(sync_raw),
        .data_o(sync_dly)
    );

    assign x_px        = h_cnt_q;
    assign y_px        = v_cnt_q;
    assign activevideo = sync_raw.act;
    assign hsync       = sync_dly.hs;
    assign vsync       = sync_dly.vs;
    assign rgb         = sync_dly.act ? color_px : COLOR_BLACK;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync.sv
// Randomised bench for vga_sync: a default 640x480 instance and a tiny-timing instance
// (active-high sync, 3-deep pipe) both checked every cycle against an elapsed-time model.
module tb_vga_sync;

    localparam int   SH_A = 8, SH_F = 2, SH_S = 3, SH_B = 2;
    localparam int   SV_A = 4, SV_F = 1, SV_S = 2, SV_B = 1;
    localparam int   S_DELAY = 3;
    localparam logic S_POL = 1'b1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] colorPx = 3'b000;
    bit         monitorOn = 1'b1;
    int         cycleN = 0;
    int         errorCount = 0;
    int         checkCount = 0;

    logic [9:0] xA, yA, xB, yB;
    logic       actA, hsA, vsA, lsA, fsA;
    logic       actB, hsB, vsB, lsB, fsB;
    logic [2:0] rgbA, rgbB;

    vga_sync dutA (
        .clk(clk), .reset(reset), .color_px(colorPx),
        .x_px(xA), .y_px(yA), .activevideo(actA), .hsync(hsA), .vsync(vsA),
        .rgb(rgbA), .line_start(lsA), .frame_start(fsA)
    );

    vga_sync #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
        .SYNC_POL(S_POL), .PIPE_DELAY(S_DELAY)
    ) dutB (
        .clk(clk), .reset(reset), .color_px(colorPx),
        .x_px(xB), .y_px(yB), .activevideo(actB), .hsync(hsB), .vsync(vsB),
        .rgb(rgbB), .line_start(lsB), .frame_start(fsB)
    );

    always #5 clk = ~clk;

    // Clocks elapsed since reset release; everything expected is derived from this alone.
    always @(posedge clk or posedge reset) begin
        if (reset) cycleN <= 0;
        else       cycleN <= cycleN + 1;
    end

    function automatic logic [27:0] modelOut(input int n, input int ha, input int hf, input int hs,
                                             input int hb, input int va, input int vf, input int vs,
                                             input int vb, input logic pol, input int d,
                                             input logic [2:0] col);
        int   ht, vt, h, v, hd, vd;
        logic hsE, vsE, actE, actD;
        logic [2:0] rgbE;
        ht   = ha + hf + hs + hb;
        vt   = va + vf + vs + vb;
        h    = n % ht;
        v    = (n / ht) % vt;
        actE = (h < ha) && (v < va);
        hsE  = ~pol;
        vsE  = ~pol;
        actD = 1'b0;
        if (n >= d) begin
            hd   = (n - d) % ht;
            vd   = ((n - d) / ht) % vt;
            hsE  = (hd >= ha + hf && hd < ha + hf + hs) ? pol : ~pol;
            vsE  = (vd >= va + vf && vd < va + vf + vs) ? pol : ~pol;
            actD = (hd < ha) && (vd < va);
        end
        rgbE = actD ? col : 3'b000;
        return {10'(h), 10'(v), actE, hsE, vsE, rgbE, (n > 0 && h == 0), (n > 0 && h == 0 && v == 0)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", tag, observed, expected, cycleN);
        end
    endtask

    always @(negedge clk) begin
        if (monitorOn) begin
            checkOutput("dflt", {4'd0, xA, yA, actA, hsA, vsA, rgbA, lsA, fsA},
                        {4'd0, modelOut(cycleN, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1, colorPx)});
            checkOutput("small", {4'd0, xB, yB, actB, hsB, vsB, rgbB, lsB, fsB},
                        {4'd0, modelOut(cycleN, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B,
                                        S_POL, S_DELAY, colorPx)});
        end
    end

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1 colorPx = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic resetAtX300();
        int budget = 0;
        while (xA !== 10'd300 && budget < 1000) begin
            applyStimulus(1);
            budget++;
        end
        checkOutput("reach300", {31'd0, xA == 10'd300}, 32'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("rstXY", {12'd0, xA, yA}, 32'd0);
        checkOutput("rstPinsA", {27'd0, hsA, vsA, rgbA}, {27'd0, 2'b11, 3'b000});
        checkOutput("rstPinsB", {24'd0, xB, hsB, vsB, rgbB}, 32'd0);
        checkOutput("rstStrobe", {28'd0, lsA, fsA, lsB, fsB}, 32'd0);
        applyStimulus(3);
        reset = 1'b0;
    endtask

    initial begin
        $display("[TB] vga_sync bench start");
        reset = 1'b1;
        applyStimulus(3);
        reset = 1'b0;
        applyStimulus(2500);
        for (int r = 0; r < 3; r++) begin
            applyStimulus($urandom_range(200, 1500));
            resetAtX300();
            applyStimulus($urandom_range(2, 40));
        end
        applyStimulus(1800);
        @(negedge clk);
        #1 monitorOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/vga_sync.md
Name: vga_sync

Overview:
- VGA 640x480@60 timing generator. Sits directly upstream of the graphics stage.
- Drives the current pixel coordinates (x_px, y_px) into graphics and receives back graphics' registered pixel colour (color_px, 1 cycle later).
- Re-aligns sync and blanking to that latency, then drives the pins: hsync, vsync and 3-bit rgb.
- Also provides frame/line strobes for animation logic such as the heart-beat "show" toggle.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- PIPE_DELAY, 1, clocks from x_px/y_px to valid color_px (1..4)

Ports:
- clk  in  1  pixel clock (25 MHz nominal)
- reset  in  1  asynchronous, active-high reset
- color_px  in  3  pixel colour from graphics, valid PIPE_DELAY clocks after the matching x_px/y_px
- x_px  out  10  horizontal counter, 0..H_TOTAL-1
- y_px  out  10  vertical counter, 0..V_TOTAL-1
- activevideo  out  1  undelayed: x_px<H_ACTIVE && y_px<V_ACTIVE
- hsync  out  1  delayed horizontal sync to pin
- vsync  out  1  delayed vertical sync to pin
- rgb  out  3  colour to pin; forced 000 when delayed blanking is active
- line_start  out  1  one-clock pulse, registered
- frame_start  out  1  one-clock pulse, registered

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - Both must be <=1024; elaborate-time error otherwise.
- Reset (async, while asserted):
  - h_cnt = v_cnt = 0.
  - Delay-line hsync/vsync stages = ~SYNC_POL (inactive); active stages = 0.
  - line_start = frame_start = 0.
  - Resulting outputs: x_px=0, y_px=0, activevideo=1, hsync=vsync=inactive, rgb=000.
- Counters:
  - h_cnt increments every clk and wraps H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
  - x_px = h_cnt and y_px = v_cnt, driven directly from the registers (no extra latency).
- Raw sync, combinational from the counters:
  - hs_raw asserted when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw asserted when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
  - Asserted level = SYNC_POL.
- Alignment pipeline:
  - PIPE_DELAY-deep shift register carries {hs_raw, vs_raw, activevideo}.
  - hsync, vsync and the delayed active flag come from the last stage.
  - rgb = act_d ? color_px : 3'b000 (combinational AND; color_px is already registered upstream).
- Strobes (registered):
  - line_start = 1 in the cycle where h_cnt==0, except the first cycle after reset release.
  - frame_start = 1 in the cycle where h_cnt==0 && v_cnt==0, same exception.
  - Implementation: set the flag register when the next counter value is 0 (i.e. current h_cnt==H_TOTAL-1).
  - Consequence: the first frame_start occurs 420000 clocks after reset release.
- Boundary conditions:
  - At the h wrap on the last line (h=799, v=524), both counters wrap in the same clock to (0,0).
  - Reset asserted mid-line: all state clears immediately and no partial strobe is emitted.
  - Pipeline contents are discarded on reset, so rgb is 000 for at least PIPE_DELAY clocks afterwards.
- No handshake: free-running; graphics must meet PIPE_DELAY exactly.

Decomposition:
- Shared package vga_pkg:
  - 640x480 timing constants (H_ACTIVE..V_BP, H_TOTAL, V_TOTAL).
  - Sync polarity constant.
  - Colour constants (black, blue, green, red, white) shared with graphics.
- One natural sub-module: vga_delay_line, a parameterised width/depth shift register with async reset value.
  - Used for the {hs, vs, active} alignment.
  - Reusable for aligning future sprite stages.

Test Plan:
- Release reset, run 2 frames -> x_px period 800 clocks; y_px increments on each x wrap, period 420000 clocks; no x_px>799 or y_px>524 ever seen.
- Default params, PIPE_DELAY=1 -> hsync low exactly 96 clocks, starting 1 clock after x_px==656; vsync low for 2 lines, starting 1 clock after (x=0,y=490).
- color_px held at 3'b100 -> rgb==100 only when the previous-cycle (x<640 && y<480), else 000; first red at 1 clock after release, last red on each line at 1 clock after x==639.
- Strobes -> frame_start pulses once per 420000 clocks, first at clock 420000 after release; line_start every 800 clocks; both single-cycle.
- Assert reset at x=300, y=200 for 3 clocks -> x_px=y_px=0 asynchronously; hsync=vsync=1, rgb=000 during reset; counting restarts from 0 on release.
- PIPE_DELAY=3, SYNC_POL=1 -> hsync high for 96 clocks starting 3 clocks after x==656; rgb blanking edges shifted by 3 clocks.
